// File: rtl/wb_regfile_pkg.sv
// Shared pipeline defines used by the execute and write-back stages:
// bus widths, enable polarities and register-file constants.
package wb_regfile_pkg;

  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;
  localparam int RegNum       = 32;

  typedef logic [RegWidth-1:0]     RegBus;
  typedef logic [RegAddrWidth-1:0] RegAddrBus;

  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam logic      RstEnable    = 1'b1;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ReadDisable  = 1'b0;
  localparam RegAddrBus NOPRegAddr   = 5'd0;

endpackage

// File: rtl/wb_regfile_array.sv
// Register storage with one synchronous write port and two raw combinational
// read ports; entry 0 is never written, out-of-range addresses read as zero.
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = RegWidth,
  parameter int ADDR_W   = RegAddrWidth,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [ADDR_W:0] NumRegsL = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;
  logic              rd1_ok;
  logic              rd2_ok;

  assign wr_ok  = (we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr))
                  && ({1'b0, waddr} < NumRegsL);
  assign rd1_ok = {1'b0, raddr1} < NumRegsL;
  assign rd2_ok = {1'b0, raddr2} < NumRegsL;

  // Reset wins over a pending write on the same edge.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = rd1_ok ? mem[raddr1] : '0;
  assign rdata2 = rd2_ok ? mem[raddr2] : '0;

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB pipeline register feeding the general-purpose register file.
// Define WB_BYPASS_EN for write-first (same-cycle) forwarding to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = RegWidth,
  parameter int ADDR_W   = RegAddrWidth,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_wr_en,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic              wb_wr_en
);

  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic              hit1;
  logic              hit2;

  // Flush beats stall so a squashed instruction never lingers in WB.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_wr_en <= WriteDisable;
    end else if (flush) begin
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_wr_en <= WriteDisable;
    end else if (!stall) begin
      wb_wdata <= in_wdata;
      wb_waddr <= in_waddr;
      wb_wr_en <= in_wr_en;
    end
  end

  wb_regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wr_en),
    .waddr  (wb_waddr),
    .wdata  (wb_wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

`ifdef WB_BYPASS_EN
  localparam logic [ADDR_W:0] NumRegsL = NUM_REGS[ADDR_W:0];
  assign hit1 = (wb_wr_en == WriteEnable) && (wb_waddr == raddr1)
                && ({1'b0, raddr1} < NumRegsL);
  assign hit2 = (wb_wr_en == WriteEnable) && (wb_waddr == raddr2)
                && ({1'b0, raddr2} < NumRegsL);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rdata1 = '0;
    if (rst != RstEnable && re1 == ReadEnable && raddr1 != ADDR_W'(NOPRegAddr)) begin
      rdata1 = hit1 ? wb_wdata : raw1;
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst != RstEnable && re2 == ReadEnable && raddr2 != ADDR_W'(NOPRegAddr)) begin
      rdata2 = hit2 ? wb_wdata : raw2;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed checks of wb_regfile against an array/struct model.
// Expectations follow WB_BYPASS_EN the same way as the design build.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_waddr;
  logic              in_wr_en;
  logic              re1, re2;
  logic [ADDR_W-1:0] raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [DATA_W-1:0] wb_wdata;
  logic [ADDR_W-1:0] wb_waddr;
  logic              wb_wr_en;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural registers and the pending WB triple.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [DATA_W-1:0] m_wdata;
  int                m_waddr;
  bit                m_wr_en;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_wdata(in_wdata), .in_waddr(in_waddr), .in_wr_en(in_wr_en),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .wb_wdata(wb_wdata), .wb_waddr(wb_waddr), .wb_wr_en(wb_wr_en)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input bit re, input int addr);
    if (rst || !re || addr == 0 || addr >= NUM_REGS) return '0;
`ifdef WB_BYPASS_EN
    if (m_wr_en && m_waddr == addr) return m_wdata;
`endif
    return m_regs[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_wdata = '0;
    m_waddr = 0;
    m_wr_en = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs held this cycle.
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      if (m_wr_en && m_waddr != 0 && m_waddr < NUM_REGS) m_regs[m_waddr] = m_wdata;
      if (flush) begin
        m_wr_en = 1'b0; m_waddr = 0; m_wdata = '0;
      end else if (!stall) begin
        m_wr_en = in_wr_en; m_waddr = int'(in_waddr); m_wdata = in_wdata;
      end
    end
  endtask

  task automatic check_all();
    #1;
    check("wb_wr_en", DATA_W'(wb_wr_en), DATA_W'(m_wr_en));
    check("wb_waddr", DATA_W'(wb_waddr), DATA_W'(m_waddr));
    check("wb_wdata", wb_wdata, m_wdata);
    check("rdata1", rdata1, model_read(re1, int'(raddr1)));
    check("rdata2", rdata2, model_read(re2, int'(raddr2)));
  endtask

  task automatic cycle();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit en, input int addr, input logic [DATA_W-1:0] data);
    in_wr_en = en;
    in_waddr = ADDR_W'(addr);
    in_wdata = data;
  endtask

  task automatic set_rd(input bit e1, input int a1, input bit e2, input int a2);
    re1 = e1; raddr1 = ADDR_W'(a1);
    re2 = e2; raddr2 = ADDR_W'(a2);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(0, 0, '0);
    set_rd(0, 0, 0, 0);
    @(posedge clk);
    model_update();
    #1;
    cycle();
    rst = 1'b0;

    // Reset clears a committed register and the WB stage.
    set_in(1, 5, 32'hDEAD_BEEF);
    cycle();
    set_in(0, 0, '0);
    set_rd(1, 5, 0, 0);
    cycle();
    #1 check("r5_before_rst", rdata1, 32'hDEAD_BEEF);
    set_in(1, 5, 32'h1111_2222);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_in(0, 0, '0);
    #1;
    check("rst_wb_wr_en", DATA_W'(wb_wr_en), '0);
    check("rst_wb_wdata", wb_wdata, '0);
    check("r5_after_rst", rdata1, 32'h0);
    cycle();

    // Write-then-read of r3.
    set_in(1, 3, 32'h1234_5678);
    set_rd(1, 3, 0, 0);
    cycle();
    set_in(0, 0, '0);
`ifdef WB_BYPASS_EN
    #1 check("r3_n1_bypass", rdata1, 32'h1234_5678);
`else
    #1 check("r3_n1_old", rdata1, 32'h0);
`endif
    cycle();
    #1 check("r3_n2", rdata1, 32'h1234_5678);
    cycle();

    // Register zero never changes.
    set_in(1, 0, 32'hFFFF_FFFF);
    set_rd(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("r0_port1", rdata1, 32'h0);
      check("r0_port2", rdata2, 32'h0);
      cycle();
    end

    // Stall holds WB, then flush beats stall.
    set_in(1, 7, 32'hA5A5_A5A5);
    set_rd(0, 0, 0, 0);
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, int'($urandom_range(1, 31)), $urandom);
      #1;
      check("stall_waddr", DATA_W'(wb_waddr), DATA_W'(7));
      check("stall_wdata", wb_wdata, 32'hA5A5_A5A5);
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0; stall = 1'b0;
    set_in(0, 0, '0);
    set_rd(0, 7, 1, 7);
    #1;
    check("flush_wr_en", DATA_W'(wb_wr_en), '0);
    check("dual_rd1_off", rdata1, 32'h0);
    check("dual_rd2_r7", rdata2, 32'hA5A5_A5A5);
    cycle();

    // Random traffic; small address range raises hazard/bypass density.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
      set_rd(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
      cycle();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
